// File: rtl/fme_pkg.sv
// Shared definitions for the 8x8 FME shift-register block: FSM states,
// block geometry and read-phase length.
package fme_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    GAP,
    READ,
    DONE
  } fme_state_e;

  localparam int FME_ROWS        = 8;
  localparam int FME_COLS        = 8;
  localparam int FME_READ_CYCLES = 8;

  localparam int FME_ROW_W = $clog2(FME_ROWS);
  localparam int FME_RD_W  = $clog2(FME_READ_CYCLES);

endpackage

// File: rtl/sr_row_feeder.sv
// Writer side of the 8x8 FME shift register: fetches 8 rows from reference
// memory, shifts them in, then runs the 8-cycle read phase and pulses done.
// Optional synchronous abort input is enabled with SR_ROW_FEEDER_ABORT_EN.
module sr_row_feeder
  import fme_pkg::*;
#(
  parameter int DATAWIDTH   = 8,
  parameter int ADDRWIDTH   = 16,
  parameter int LINE_STRIDE = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ADDRWIDTH-1:0]          base_addr,
`ifdef SR_ROW_FEEDER_ABORT_EN
  input  logic                          abort,
`endif
  output logic                          busy,
  output logic                          done,
  output logic                          mem_req,
  output logic [ADDRWIDTH-1:0]          mem_addr,
  input  logic                          mem_valid,
  input  logic [FME_COLS*DATAWIDTH-1:0] mem_data,
  output logic [DATAWIDTH-1:0]          sr_in_0,
  output logic [DATAWIDTH-1:0]          sr_in_1,
  output logic [DATAWIDTH-1:0]          sr_in_2,
  output logic [DATAWIDTH-1:0]          sr_in_3,
  output logic [DATAWIDTH-1:0]          sr_in_4,
  output logic [DATAWIDTH-1:0]          sr_in_5,
  output logic [DATAWIDTH-1:0]          sr_in_6,
  output logic [DATAWIDTH-1:0]          sr_in_7,
  output logic                          sr_enable,
  output logic                          sr_enable_read
);

  localparam logic [FME_ROW_W-1:0] LAST_ROW = FME_ROW_W'(FME_ROWS - 1);
  localparam logic [FME_RD_W-1:0]  LAST_RD  = FME_RD_W'(FME_READ_CYCLES - 1);

  fme_state_e             r_state;
  logic [FME_ROW_W-1:0]   r_row_cnt;
  logic [FME_RD_W-1:0]    r_rd_cnt;
  logic [ADDRWIDTH-1:0]   r_base;
  logic [ADDRWIDTH-1:0]   r_mem_addr;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_mem_req;
  logic                   r_sr_enable;
  logic                   r_sr_enable_read;
  logic [DATAWIDTH-1:0]   r_sr_in [FME_COLS];

  logic                   w_abort;
  logic [ADDRWIDTH-1:0]   w_next_row;
  logic [ADDRWIDTH-1:0]   w_next_addr;

`ifdef SR_ROW_FEEDER_ABORT_EN
  assign w_abort = abort && (r_state != IDLE);
`else
  assign w_abort = 1'b0;
`endif

  // Address of the following row; modulo 2^ADDRWIDTH so the window may wrap.
  assign w_next_row  = ADDRWIDTH'(r_row_cnt) + ADDRWIDTH'(1);
  assign w_next_addr = r_base + w_next_row * ADDRWIDTH'(LINE_STRIDE);

  // NOTE: every register here, including the pixel datapath, is cleared by
  // reset because sr_in_* are block outputs that must read 0 out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state          <= IDLE;
      r_row_cnt        <= '0;
      r_rd_cnt         <= '0;
      r_base           <= '0;
      r_mem_addr       <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_mem_req        <= 1'b0;
      r_sr_enable      <= 1'b0;
      r_sr_enable_read <= 1'b0;
      for (int p = 0; p < FME_COLS; p++) begin
        r_sr_in[p] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments throughout; the defaults below make
      // done and sr_enable single-cycle pulses unless a state re-asserts them.
      r_done      <= 1'b0;
      r_sr_enable <= 1'b0;

      if (w_abort) begin
        r_state          <= IDLE;
        r_busy           <= 1'b0;
        r_mem_req        <= 1'b0;
        r_sr_enable_read <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            // A start coinciding with the done pulse belongs to the old job.
            if (start && !r_done) begin
              r_base     <= base_addr;
              r_mem_addr <= base_addr;
              r_row_cnt  <= '0;
              r_busy     <= 1'b1;
              r_mem_req  <= 1'b1;
              r_state    <= REQ;
            end
          end

          REQ: begin
            if (mem_valid) begin
              for (int p = 0; p < FME_COLS; p++) begin
                r_sr_in[p] <= mem_data[p*DATAWIDTH +: DATAWIDTH];
              end
              r_sr_enable <= 1'b1;
              r_mem_req   <= 1'b0;
              r_row_cnt   <= r_row_cnt + FME_ROW_W'(1);
              if (r_row_cnt == LAST_ROW) begin
                r_state <= GAP;
              end else begin
                r_mem_addr <= w_next_addr;
                r_state    <= WAIT;
              end
            end
          end

          WAIT: begin
            r_mem_req <= 1'b1;
            r_state   <= REQ;
          end

          GAP: begin
            r_rd_cnt         <= '0;
            r_sr_enable_read <= 1'b1;
            r_state          <= READ;
          end

          READ: begin
            if (r_rd_cnt == LAST_RD) begin
              r_sr_enable_read <= 1'b0;
              r_state          <= DONE;
            end else begin
              r_rd_cnt <= r_rd_cnt + FME_RD_W'(1);
            end
          end

          DONE: begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end

          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign mem_req        = r_mem_req;
  assign mem_addr       = r_mem_addr;
  assign sr_enable      = r_sr_enable;
  assign sr_enable_read = r_sr_enable_read;
  assign sr_in_0        = r_sr_in[0];
  assign sr_in_1        = r_sr_in[1];
  assign sr_in_2        = r_sr_in[2];
  assign sr_in_3        = r_sr_in[3];
  assign sr_in_4        = r_sr_in[4];
  assign sr_in_5        = r_sr_in[5];
  assign sr_in_6        = r_sr_in[6];
  assign sr_in_7        = r_sr_in[7];

endmodule

// File: tb/tb_sr_row_feeder.sv
// Scoreboard bench for sr_row_feeder: stimulus pushes expected address, row,
// read and done events; an independent monitor pops and compares them.
module tb_sr_row_feeder;

  localparam int DW = 8;
  localparam int AW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
`ifdef SR_ROW_FEEDER_ABORT_EN
  logic          abort;
`endif
  logic          busy, done, mem_req, mem_valid;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_data;
  logic [DW-1:0] sr_in_0, sr_in_1, sr_in_2, sr_in_3;
  logic [DW-1:0] sr_in_4, sr_in_5, sr_in_6, sr_in_7;
  logic          sr_enable, sr_enable_read;

  sr_row_feeder #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .LINE_STRIDE(1)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
`ifdef SR_ROW_FEEDER_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_data(mem_data),
    .sr_in_0(sr_in_0), .sr_in_1(sr_in_1), .sr_in_2(sr_in_2), .sr_in_3(sr_in_3),
    .sr_in_4(sr_in_4), .sr_in_5(sr_in_5), .sr_in_6(sr_in_6), .sr_in_7(sr_in_7),
    .sr_enable(sr_enable), .sr_enable_read(sr_enable_read)
  );

  always #5 clock = ~clock;

  typedef enum int {EV_ADDR, EV_ROW, EV_READ, EV_DONE} ev_e;
  typedef struct {
    ev_e         kind;
    logic [63:0] val;
  } exp_t;

  exp_t          sb[$];
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  int            mem_lat  = 0;
  int            mem_mode = 0;
  logic [AW-1:0] mem_base = '0;
  bit            spur = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [63:0] sr_vec();
    return {sr_in_7, sr_in_6, sr_in_5, sr_in_4, sr_in_3, sr_in_2, sr_in_1, sr_in_0};
  endfunction

  // Memory contents: mode 0 fills row r with r+1; mode 1 gives pixel p of
  // row r the value 16*r + p + 1 so any pixel reordering is visible.
  function automatic logic [63:0] row_word(input logic [AW-1:0] row, input int mode);
    logic [63:0] w;
    for (int p = 0; p < 8; p++) begin
      if (mode == 0) w[p*8 +: 8] = 8'(int'(row) + 1);
      else           w[p*8 +: 8] = 8'(int'(row) * 16 + p + 1);
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic observe(input ev_e kind, input logic [63:0] val, input string name);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s: unexpected %s %h with nothing expected", name, kind.name(), val);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.val !== val) begin
        bad++;
        $display("FAIL %s: got %s %h expected %s %h", name, kind.name(), val,
                 e.kind.name(), e.val);
      end
    end
  endtask

  task automatic push(input ev_e kind, input logic [63:0] val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  // Done lands in the 27th cycle counting the start cycle as the first,
  // plus the extra memory wait of every row.
  task automatic push_seq(input logic [AW-1:0] base, input int lat, input int mode,
                          input int sc, input int rows, input int reads, input bit with_done);
    logic [AW-1:0] a;
    for (int r = 0; r < rows; r++) begin
      a = base + AW'(r);
      push(EV_ADDR, 64'(a));
      push(EV_ROW, row_word(AW'(r), mode));
    end
    for (int i = 0; i < reads; i++) push(EV_READ, 64'(i));
    if (with_done) push(EV_DONE, 64'(sc + 27 - 1 + 8 * lat));
  endtask

  // Drive start in the current cycle (caller is already at negedge+2).
  task automatic issue_now(input logic [AW-1:0] base, input int lat, input int mode,
                           input int rows, input int reads, input bit with_done, output int sc);
    mem_lat   = lat;
    mem_mode  = mode;
    mem_base  = base;
    base_addr = base;
    start     = 1'b1;
    sc        = cyc;
    push_seq(base, lat, mode, sc, rows, reads, with_done);
    @(negedge clock); #2;
    start     = 1'b0;
    base_addr = 16'h5A5A;
  endtask

  task automatic issue(input logic [AW-1:0] base, input int lat, input int mode,
                       input int rows, input int reads, input bit with_done, output int sc);
    @(negedge clock); #2;
    issue_now(base, lat, mode, rows, reads, with_done, sc);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clock); #2;
      n++;
    end
    check({name, "_pending_events"}, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(negedge clock); #2;
    end
  endtask

  // Memory responder: answers each request after mem_lat extra cycles and
  // optionally injects stray mem_valid strobes while no request is open.
  initial begin
    bit            waiting = 1'b0;
    int            wcnt    = 0;
    logic [AW-1:0] held    = '0;
    mem_valid = 1'b0;
    mem_data  = '0;
    forever begin
      @(negedge clock);
      mem_valid = 1'b0;
      if (mem_req && !reset) begin
        if (!waiting) begin
          waiting = 1'b1;
          wcnt    = 0;
          held    = mem_addr;
        end else begin
          check("mem_addr_stable", 64'(mem_addr), 64'(held));
        end
        if (wcnt == mem_lat) begin
          mem_valid = 1'b1;
          mem_data  = row_word(mem_addr - mem_base, mem_mode);
          waiting   = 1'b0;
        end else begin
          wcnt++;
        end
      end else begin
        waiting = 1'b0;
        if (spur) begin
          mem_valid = 1'b1;
          mem_data  = 64'hDEAD_BEEF_0BAD_F00D;
        end
      end
    end
  end

  // Monitor: turns DUT activity into events and compares against the queue.
  initial begin
    int rd_idx = 0;
    forever begin
      @(negedge clock); #1;
      if (!reset) begin
        if (mem_req && mem_valid) observe(EV_ADDR, 64'(mem_addr), "mem_addr");
        if (sr_enable) observe(EV_ROW, sr_vec(), "sr_row");
        if (sr_enable_read) begin
          observe(EV_READ, 64'(rd_idx), "read_index");
          rd_idx++;
        end else begin
          rd_idx = 0;
        end
        if (done) begin
          observe(EV_DONE, 64'(cyc), "done_cycle");
          check("busy_with_done", 64'(busy), 64'd0);
        end
        if (sr_enable || sr_enable_read)
          check("enable_overlap", 64'(sr_enable & sr_enable_read), 64'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc, sc2;
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
`ifdef SR_ROW_FEEDER_ABORT_EN
    abort     = 1'b0;
`endif
    repeat (2) @(negedge clock);
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_sr_in", sr_vec(), 64'd0);
    check("rst_enables", 64'({sr_enable, sr_enable_read}), 64'd0);
    reset = 1'b0;

    // Zero-latency fetch from 0x0100, rows filled with r+1.
    issue(16'h0100, 0, 0, 8, 8, 1'b1, sc);
    drain("zero_latency", 100);

    // Stray mem_valid while idle: no shift, sr_in keeps row 7.
    spur = 1'b1;
    repeat (3) begin @(negedge clock); #2; end
    spur = 1'b0;
    repeat (2) begin @(negedge clock); #2; end
    check("idle_spur_sr_in", sr_vec(), 64'h0808_0808_0808_0808);
    check("idle_spur_busy", 64'(busy), 64'd0);

    // Three-cycle memory latency; then start during done, then start next cycle.
    issue(16'h2000, 3, 1, 8, 8, 1'b1, sc);
    wait_cyc(sc + 50);
    check("late_queue_empty", 64'(sb.size()), 64'd0);
    start     = 1'b1;
    base_addr = 16'h5555;
    @(negedge clock); #2;
    check("start_at_done_busy", 64'(busy), 64'd0);
    check("start_at_done_req", 64'(mem_req), 64'd0);

    // Accepted start with wrapping addresses; stray mem_valid during READ.
    issue_now(16'hFFFE, 0, 1, 8, 8, 1'b1, sc2);
    wait_cyc(sc2 + 18);
    spur = 1'b1;
    repeat (3) begin @(negedge clock); #2; end
    spur = 1'b0;
    drain("wrap_and_read_spur", 100);

    // Reset in the middle of the read phase (rd_cnt = 3).
    issue(16'h0300, 0, 0, 8, 4, 1'b0, sc);
    wait_cyc(sc + 20);
    check("pre_reset_read", 64'(sr_enable_read), 64'd1);
    reset = 1'b1;
    #1;
    check("async_rst_read", 64'(sr_enable_read), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_sr_in", sr_vec(), 64'd0);
    check("async_rst_addr", 64'(mem_addr), 64'd0);
    check("rst_queue_empty", 64'(sb.size()), 64'd0);
    sb.delete();
    @(negedge clock); #2;
    reset = 1'b0;
    issue(16'h0000, 0, 1, 8, 8, 1'b1, sc);
    drain("after_reset", 100);

`ifdef SR_ROW_FEEDER_ABORT_EN
    // Abort in the first REQ cycle of row 4, then restart one cycle later.
    issue(16'h0400, 2, 1, 4, 0, 1'b0, sc);
    wait_cyc(sc + 17);
    check("abort_pre_req", 64'(mem_req), 64'd1);
    abort = 1'b1;
    @(negedge clock); #2;
    abort = 1'b0;
    check("abort_mem_req", 64'(mem_req), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_sr_in_kept", sr_vec(), row_word(16'd3, 1));
    check("abort_queue_empty", 64'(sb.size()), 64'd0);
    issue_now(16'h0500, 0, 0, 8, 8, 1'b1, sc);
    drain("abort_restart", 100);
`endif

    repeat (2) begin @(negedge clock); #2; end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sr_row_feeder.md
Name: sr_row_feeder

Overview:
- Writer side of the 8x8 FME shift register.
- Fetches 8 rows of 8 pixels from reference-pixel memory, one request at a time.
- Drives each row onto the shift-register row inputs with a one-cycle enable pulse.
- After the last row, asserts the read enable for 8 consecutive cycles so the register can present its 8 column/row selections to the SAD tree. Then reports done.

Parameters:
- DATAWIDTH, 8, bits per pixel.
- ADDRWIDTH, 16, memory word-address width.
- LINE_STRIDE, 1, address increment between consecutive rows.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin one block load; sampled only in IDLE.
- base_addr  input  ADDRWIDTH  address of row 0; captured when start is accepted.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the last read-enable cycle.
- mem_req  output  1  request valid; held high until mem_valid.
- mem_addr  output  ADDRWIDTH  row address; stable while mem_req is high.
- mem_valid  input  1  response strobe; data on mem_data in the same cycle.
- mem_data  input  8*DATAWIDTH  pixel p at bits [p*DATAWIDTH +: DATAWIDTH].
- sr_in_0..sr_in_7  output  DATAWIDTH each  row pixels 0..7 to the shift register.
- sr_enable  output  1  shift strobe, one cycle per row.
- sr_enable_read  output  1  read-phase enable, 8 consecutive cycles.

Behaviour:
- Reset (asynchronous, any state) forces:
  - state = IDLE; row_cnt = 0; rd_cnt = 0.
  - all outputs 0, including the sr_in_* registers and mem_addr.
- States:
  - IDLE: start=1 captures base_addr and sets row_cnt=0, then goes to REQ. While not in IDLE, start is ignored.
  - REQ: mem_req=1 and mem_addr = base_addr + row_cnt*LINE_STRIDE, modulo 2^ADDRWIDTH (wrap-around allowed). On mem_valid=1:
    - register mem_data slices into sr_in_0..7 (pixel p into sr_in_p);
    - assert sr_enable for exactly the next cycle;
    - row_cnt++.
    - If row_cnt was 7, go to GAP; otherwise go to WAIT.
  - WAIT: one cycle with mem_req=0 while sr_enable is high, then REQ. This allows one outstanding request and a one-cycle bubble per row.
  - GAP: one cycle (sr_enable high for row 7), then READ with rd_cnt=0.
  - READ: sr_enable_read=1 for rd_cnt = 0..7, with sr_enable=0. After rd_cnt=7, go to DONE.
  - DONE: done=1 for one cycle, busy=0 in the same cycle, then IDLE.
- Timing:
  - sr_enable and sr_enable_read are never high in the same cycle.
  - sr_in_* holds the last row until the next mem_valid.
  - Zero-latency memory (mem_valid in the first REQ cycle): each row costs 2 cycles. Total from start to done is 1 + 16 + 1 + 8 + 1 = 27 cycles.
- Boundary cases:
  - mem_valid outside REQ is ignored (no shift, no count).
  - start asserted in the same cycle as done: ignored. A new start is accepted in IDLE on the following cycle.
  - Reset during READ: sr_enable_read drops immediately (asynchronous). The shift register's own reset clears its counter.

Optional Feature:
- Macro: SR_ROW_FEEDER_ABORT_EN
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in any non-IDLE state synchronously returns the block to IDLE on the next edge.
  - busy, mem_req, sr_enable and sr_enable_read go to 0.
  - done is not pulsed.
  - sr_in_* is unchanged.
  - abort in IDLE has no effect; abort takes priority over start and mem_valid.
- Undefined: no abort port; the sequence always runs to completion.

Decomposition:
- Shared package fme_pkg holds:
  - the state enum (IDLE, REQ, WAIT, GAP, READ, DONE);
  - FME_ROWS = 8 and FME_COLS = 8;
  - the read-phase length constant, FME_READ_CYCLES = 8.
- No sub-module is natural. The address generator is one adder and stays inline with the FSM in a single file.

Test Plan:
- Zero-latency memory, base_addr=16'h0100, row r data = {8{8'(r+1)}}:
  - mem_addr sequence is 0x0100..0x0107;
  - eight single-cycle sr_enable pulses, each with sr_in_* equal to r+1;
  - then 8 cycles of sr_enable_read, and done at cycle 27 after start.
- mem_valid delayed 3 cycles per row:
  - mem_addr is stable while mem_req is high;
  - done occurs at cycle 27 + 8*3 = 51.
- Wrap-around with base_addr=16'hFFFE and LINE_STRIDE=1: addresses FFFE, FFFF, 0000..0005.
- Spurious mem_valid in IDLE and in READ: no sr_enable pulse; row_cnt and rd_cnt unaffected.
- Reset asserted mid-READ at rd_cnt=3:
  - all outputs 0 asynchronously;
  - a following start with base_addr=0 yields a clean 27-cycle sequence.
- With SR_ROW_FEEDER_ABORT_EN: abort during row 4 REQ gives mem_req=0 and busy=0 on the next cycle, with no done pulse. A restart with start=1 is accepted 1 cycle later.
